// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the weighted round-robin bus arbiter
package arb_pkg;

  localparam int NUM_CLIENTS = 4;
  localparam int ADDR_W      = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    SELECT   = 2'b01,
    WAIT_ACK = 2'b10
  } arb_state_t;

  localparam logic [ADDR_W-1:0] CLIENT_0 = 2'b00;
  localparam logic [ADDR_W-1:0] CLIENT_1 = 2'b01;
  localparam logic [ADDR_W-1:0] CLIENT_2 = 2'b10;
  localparam logic [ADDR_W-1:0] CLIENT_3 = 2'b11;

  // One-hot decode of a client address, used for the registered grant vector.
  function automatic logic [NUM_CLIENTS-1:0] addr_to_onehot(input logic [ADDR_W-1:0] addr);
    return NUM_CLIENTS'(1) << addr;
  endfunction

endpackage

// File: rtl/rr_credit_picker.sv
// rtl/rr_credit_picker.sv - rotating priority search over requesters that still hold credit
module rr_credit_picker
  import arb_pkg::*;
(
  input  logic [NUM_CLIENTS-1:0] rq,
  input  logic [NUM_CLIENTS-1:0] credit_nz,
  input  logic [ADDR_W-1:0]      rr_ptr,
  output logic                   found,
  output logic [ADDR_W-1:0]      index
);

  logic [NUM_CLIENTS-1:0] eligible;
  logic [NUM_CLIENTS-1:0] rotated;
  logic [ADDR_W-1:0]      offset;

  // Rotate so rr_ptr lands at bit 0, take the lowest set bit, then rotate back.
  always_comb begin
    eligible = rq & credit_nz;
    rotated  = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      rotated[i] = eligible[ADDR_W'(i) + rr_ptr];
    end
    found = |rotated;
    casez (rotated)
      4'b???1: offset = CLIENT_0;
      4'b??10: offset = CLIENT_1;
      4'b?100: offset = CLIENT_2;
      4'b1000: offset = CLIENT_3;
      default: offset = CLIENT_0;
    endcase
    index = rr_ptr + offset;
  end

endmodule

// File: rtl/wrr_arbiter_logic.sv
// rtl/wrr_arbiter_logic.sv - 4-client weighted round-robin arbiter; ARB_TIMEOUT_EN adds an ack watchdog
module wrr_arbiter_logic
  import arb_pkg::*;
#(
  parameter int WEIGHT_W       = 3,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [NUM_CLIENTS-1:0]          client_rq,
  input  logic [NUM_CLIENTS*WEIGHT_W-1:0] client_weight,
  input  logic                            server_ack,
  output logic [ADDR_W-1:0]               address_to_be_served,
  output logic                            grant_valid,
  output logic [NUM_CLIENTS-1:0]          grant_onehot,
  output logic                            timeout_pulse
);

  arb_state_t             state;
  logic [ADDR_W-1:0]      rr_ptr;
  logic [WEIGHT_W-1:0]    credit [NUM_CLIENTS];
  logic [NUM_CLIENTS-1:0] credit_nz;
  logic                   pick_found;
  logic [ADDR_W-1:0]      pick_idx;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] wait_cnt;
  logic       timeout_hit;

  // Watchdog fires on the last allowed WAIT_ACK cycle; ack in that cycle still wins.
  always_comb begin
    timeout_hit = (wait_cnt == TIMEOUT_LAST);
  end
`else
  // Watchdog compiled out: the timeout length has no effect in this build.
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_pulse      = 1'b0;
`endif

  // A client is only eligible while it still has burst credit this round.
  always_comb begin
    credit_nz = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      credit_nz[i] = (credit[i] != '0);
    end
  end

  rr_credit_picker u_picker (
    .rq        (client_rq),
    .credit_nz (credit_nz),
    .rr_ptr    (rr_ptr),
    .found     (pick_found),
    .index     (pick_idx)
  );

  // Arbiter FSM: idle, pick-or-replenish, then hold the grant until ack (or watchdog).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                <= IDLE;
      address_to_be_served <= CLIENT_0;
      grant_valid          <= 1'b0;
      grant_onehot         <= '0;
      rr_ptr               <= CLIENT_0;
      for (int i = 0; i < NUM_CLIENTS; i++) begin
        credit[i] <= '0;
      end
`ifdef ARB_TIMEOUT_EN
      timeout_pulse        <= 1'b0;
      wait_cnt             <= '0;
`endif
    end else if (enable) begin
`ifdef ARB_TIMEOUT_EN
      timeout_pulse <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (client_rq != '0) begin
            state <= SELECT;
          end
        end

        SELECT: begin
          if (client_rq == '0) begin
            state <= IDLE;
          end else if (pick_found) begin
            address_to_be_served <= pick_idx;
            grant_onehot         <= addr_to_onehot(pick_idx);
            grant_valid          <= 1'b1;
            credit[pick_idx]     <= credit[pick_idx] - WEIGHT_W'(1);
            state                <= WAIT_ACK;
`ifdef ARB_TIMEOUT_EN
            wait_cnt             <= '0;
`endif
          end else begin
            // Round exhausted: reload all credits; a zero weight still earns one grant.
            for (int i = 0; i < NUM_CLIENTS; i++) begin
              if (client_weight[i*WEIGHT_W +: WEIGHT_W] == '0) begin
                credit[i] <= WEIGHT_W'(1);
              end else begin
                credit[i] <= client_weight[i*WEIGHT_W +: WEIGHT_W];
              end
            end
          end
        end

        WAIT_ACK: begin
          if (server_ack) begin
            grant_valid  <= 1'b0;
            grant_onehot <= '0;
            // Stay on the same client while it has credit left, so its burst continues.
            if (credit[address_to_be_served] == '0) begin
              rr_ptr <= address_to_be_served + ADDR_W'(1);
            end else begin
              rr_ptr <= address_to_be_served;
            end
            state <= SELECT;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            grant_valid                  <= 1'b0;
            grant_onehot                 <= '0;
            timeout_pulse                <= 1'b1;
            credit[address_to_be_served] <= '0;
            rr_ptr                       <= address_to_be_served + ADDR_W'(1);
            state                        <= SELECT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
`endif
        end

        default: begin
          state                <= IDLE;
          address_to_be_served <= CLIENT_0;
          grant_valid          <= 1'b0;
          grant_onehot         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wrr_arbiter_logic.sv
// tb/tb_wrr_arbiter_logic.sv - self-checking bench for wrr_arbiter_logic (ARB_TIMEOUT_EN optional)
module tb_wrr_arbiter_logic;

  localparam int WEIGHT_W       = 3;
  localparam int TIMEOUT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [3:0]  client_rq;
  logic [11:0] client_weight;
  logic        server_ack;
  logic [1:0]  address_to_be_served;
  logic        grant_valid;
  logic [3:0]  grant_onehot;
  logic        timeout_pulse;

  always #5 clk = ~clk;

  wrr_arbiter_logic #(
    .WEIGHT_W       (WEIGHT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk                  (clk),
    .reset                (reset),
    .enable               (enable),
    .client_rq            (client_rq),
    .client_weight        (client_weight),
    .server_ack           (server_ack),
    .address_to_be_served (address_to_be_served),
    .grant_valid          (grant_valid),
    .grant_onehot         (grant_onehot),
    .timeout_pulse        (timeout_pulse)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d", name, act, exp);
  endtask

  // Reference model: phase 0 idle, 1 choosing, 2 granted and waiting.
  int m_phase, m_ptr, m_addr, m_gv, m_pulse, m_wait;
  int m_credit [4];

  task automatic model_reset();
    m_phase = 0; m_ptr = 0; m_addr = 0; m_gv = 0; m_pulse = 0; m_wait = 0;
    for (int c = 0; c < 4; c++) m_credit[c] = 0;
  endtask

  task automatic model_step(input bit en, input logic [3:0] rq, input logic [11:0] w, input bit ack);
    int pick;
    int wt;
    if (!en) return;
    m_pulse = 0;
    if (m_phase == 0) begin
      if (rq != 0) m_phase = 1;
    end else if (m_phase == 1) begin
      if (rq == 0) m_phase = 0;
      else begin
        pick = -1;
        for (int k = 0; k < 4; k++) begin
          int c;
          c = (m_ptr + k) % 4;
          if (pick < 0 && rq[c] && m_credit[c] > 0) pick = c;
        end
        if (pick >= 0) begin
          m_addr = pick; m_gv = 1; m_credit[pick] -= 1; m_wait = 0; m_phase = 2;
        end else begin
          for (int c = 0; c < 4; c++) begin
            wt = int'(w[c*3 +: 3]);
            m_credit[c] = (wt == 0) ? 1 : wt;
          end
        end
      end
    end else begin
      if (ack) begin
        m_gv = 0;
        m_ptr = (m_credit[m_addr] == 0) ? (m_addr + 1) % 4 : m_addr;
        m_phase = 1;
      end
`ifdef ARB_TIMEOUT_EN
      else if (m_wait == TIMEOUT_CYCLES - 1) begin
        m_gv = 0; m_pulse = 1; m_credit[m_addr] = 0;
        m_ptr = (m_addr + 1) % 4; m_phase = 1;
      end else m_wait++;
`endif
    end
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".gv"}, int'(grant_valid), m_gv);
    check({tag, ".addr"}, int'(address_to_be_served), m_addr);
    check({tag, ".onehot"}, int'(grant_onehot), m_gv ? (1 << m_addr) : 0);
    check({tag, ".pulse"}, int'(timeout_pulse), m_pulse);
  endtask

  task automatic cycle(input bit en, input logic [3:0] rq, input bit ack, input string tag);
    enable = en; client_rq = rq; server_ack = ack;
    @(posedge clk);
    model_step(en, rq, client_weight, ack);
    #1;
    compare_model(tag);
  endtask

  task automatic apply_reset();
    reset = 1'b1; enable = 1'b0; client_rq = '0; server_ack = 1'b0;
    #2;
    model_reset();
    compare_model("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic [3:0] rq;
    bit         ack;
    bit         gv;
    logic [1:0] addr;
  } vec_t;

  vec_t tbl [20];

  initial begin
    int grants;

    // Weights 1,2,1,3 with all clients requesting: 0,1,1,2,3,3,3 then replenish.
    tbl[0]  = '{4'hF, 1'b0, 1'b0, 2'd0};
    tbl[1]  = '{4'hF, 1'b0, 1'b0, 2'd0};
    tbl[2]  = '{4'hF, 1'b0, 1'b1, 2'd0};
    tbl[3]  = '{4'hF, 1'b1, 1'b0, 2'd0};
    tbl[4]  = '{4'hF, 1'b0, 1'b1, 2'd1};
    tbl[5]  = '{4'hF, 1'b1, 1'b0, 2'd1};
    tbl[6]  = '{4'hF, 1'b0, 1'b1, 2'd1};
    tbl[7]  = '{4'hF, 1'b1, 1'b0, 2'd1};
    tbl[8]  = '{4'hF, 1'b0, 1'b1, 2'd2};
    tbl[9]  = '{4'hF, 1'b1, 1'b0, 2'd2};
    tbl[10] = '{4'hF, 1'b0, 1'b1, 2'd3};
    tbl[11] = '{4'hF, 1'b1, 1'b0, 2'd3};
    tbl[12] = '{4'hF, 1'b0, 1'b1, 2'd3};
    tbl[13] = '{4'hF, 1'b1, 1'b0, 2'd3};
    tbl[14] = '{4'hF, 1'b0, 1'b1, 2'd3};
    tbl[15] = '{4'hF, 1'b1, 1'b0, 2'd3};
    tbl[16] = '{4'hF, 1'b0, 1'b0, 2'd3};
    tbl[17] = '{4'hF, 1'b0, 1'b1, 2'd0};
    tbl[18] = '{4'hF, 1'b1, 1'b0, 2'd0};
    tbl[19] = '{4'hF, 1'b0, 1'b1, 2'd1};

    client_weight = {3'd3, 3'd1, 3'd2, 3'd1};
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, tbl[i].rq, tbl[i].ack, "fair");
      check($sformatf("tbl%0d.gv", i), int'(grant_valid), int'(tbl[i].gv));
      check($sformatf("tbl%0d.addr", i), int'(address_to_be_served), int'(tbl[i].addr));
      check($sformatf("tbl%0d.onehot", i), int'(grant_onehot), tbl[i].gv ? (1 << tbl[i].addr) : 0);
    end

    // Single requester with weight 0: grant, ack, replenish, grant ... period of 3 cycles.
    client_weight = 12'h000;
    apply_reset();
    for (int i = 0; i < 15; i++) begin
      cycle(1'b1, 4'b0100, bit'(m_gv), "single");
      check($sformatf("single%0d.gv", i), int'(grant_valid), (i >= 2 && (i - 2) % 3 == 0) ? 1 : 0);
      if (i >= 2) check($sformatf("single%0d.addr", i), int'(address_to_be_served), 2);
    end

    // Request dropped during a grant to client 1.
    client_weight = {3'd1, 3'd1, 3'd1, 3'd1};
    apply_reset();
    cycle(1'b1, 4'b0010, 1'b0, "drop");
    cycle(1'b1, 4'b0010, 1'b0, "drop");
    cycle(1'b1, 4'b0010, 1'b0, "drop");
    check("drop.granted", int'(address_to_be_served), 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'b0000, 1'b0, "drop");
      check("drop.held", int'(grant_valid), 1);
    end
    cycle(1'b1, 4'b0101, 1'b1, "drop");
    check("drop.released", int'(grant_valid), 0);
    cycle(1'b1, 4'b0101, 1'b0, "drop");
    check("drop.next_gv", int'(grant_valid), 1);
    check("drop.next_addr", int'(address_to_be_served), 2);

    // Freeze in WAIT_ACK: ack pulses while disabled are ignored.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 4'b0101, i[0], "freeze");
      check("freeze.gv", int'(grant_valid), 1);
      check("freeze.addr", int'(address_to_be_served), 2);
    end
    cycle(1'b1, 4'b0101, 1'b1, "freeze");
    check("freeze.ack_gv", int'(grant_valid), 0);
    cycle(1'b1, 4'b0101, 1'b0, "freeze");
    check("freeze.next_addr", int'(address_to_be_served), 0);
    check("freeze.next_gv", int'(grant_valid), 1);

    // Asynchronous reset while a grant is held.
    reset = 1'b1;
    #2;
    check("rst_mid.gv", int'(grant_valid), 0);
    check("rst_mid.onehot", int'(grant_onehot), 0);
    check("rst_mid.addr", int'(address_to_be_served), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    cycle(1'b1, 4'b1010, 1'b0, "rst_after");
    cycle(1'b1, 4'b1010, 1'b0, "rst_after");
    check("rst_after.replenish", int'(grant_valid), 0);
    cycle(1'b1, 4'b1010, 1'b0, "rst_after");
    check("rst_after.gv", int'(grant_valid), 1);
    check("rst_after.addr", int'(address_to_be_served), 1);

`ifdef ARB_TIMEOUT_EN
    // Client 0 never acked: pulse after 8 WAIT_ACK cycles, then client 1 is served.
    client_weight = {3'd1, 3'd1, 3'd1, 3'd1};
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0011, 1'b0, "tmo");
    check("tmo.grant0", int'(address_to_be_served), 0);
    for (int j = 1; j <= 8; j++) begin
      cycle(1'b1, 4'b0011, 1'b0, "tmo");
      check($sformatf("tmo%0d.pulse", j), int'(timeout_pulse), (j == 8) ? 1 : 0);
      check($sformatf("tmo%0d.gv", j), int'(grant_valid), (j == 8) ? 0 : 1);
    end
    cycle(1'b1, 4'b0011, 1'b0, "tmo");
    check("tmo.pulse_off", int'(timeout_pulse), 0);
    check("tmo.next_addr", int'(address_to_be_served), 1);
    check("tmo.next_gv", int'(grant_valid), 1);

    // Ack in the 8th cycle beats the watchdog.
    apply_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 4'b0011, 1'b0, "tmo_ack");
    for (int j = 1; j <= 8; j++) begin
      cycle(1'b1, 4'b0011, (j == 8), "tmo_ack");
      check($sformatf("tmo_ack%0d.pulse", j), int'(timeout_pulse), 0);
    end
    check("tmo_ack.gv", int'(grant_valid), 0);
`endif

    // Randomized traffic against the reference model.
    apply_reset();
    client_rq = 4'hF;
    for (int i = 0; i < 800; i++) begin
      logic [3:0] rq;
      if ($urandom_range(0, 49) == 0) client_weight = 12'($urandom);
      rq = ($urandom_range(0, 3) == 0) ? 4'($urandom) : client_rq;
      cycle($urandom_range(0, 9) != 0, rq, bit'(m_gv) && ($urandom_range(0, 2) == 0), "rand");
    end

    grants = n_checks;
    if (grants < 12) check("check_count", grants, 12);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/wrr_arbiter_logic.md
Name: wrr_arbiter_logic

Overview:
- Weighted round-robin arbiter for the 4-client bus arbiter. It is the companion scheduler to the strict-priority path.
- Each client receives up to its programmed weight of consecutive grants per round. The rotation then moves on.
- Drives the 2-bit address of the served client toward the server mux and holds each grant until server_ack.

Parameters:
- WEIGHT_W, 3, width of each client weight and credit counter. Max burst per round is 2^WEIGHT_W-1.
- TIMEOUT_CYCLES, 64, ack timeout length. Used only with ARB_TIMEOUT_EN.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  FSM advances only when high.
- client_rq  in  4  request per client; bit i is client i.
- client_weight  in  4*WEIGHT_W  packed weights; client i at [i*WEIGHT_W +: WEIGHT_W].
- server_ack  in  1  server finished the current transfer.
- address_to_be_served  out  2  granted client index.
- grant_valid  out  1  grant active; address_to_be_served is meaningful.
- grant_onehot  out  4  one-hot copy of the granted client; zero when grant_valid=0.
- timeout_pulse  out  1  one-cycle pulse on ack timeout. Tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- Reset (async): state=IDLE, address_to_be_served=0, grant_valid=0, grant_onehot=0, timeout_pulse=0, all credits=0, rr_ptr=0.
- enable=0: state, credits, rr_ptr and all outputs hold. server_ack is ignored.
- IDLE: if client_rq!=0, go to SELECT; otherwise stay.
- SELECT, client search:
  - Scan clients rr_ptr, rr_ptr+1, ... mod 4.
  - Pick the first client with rq=1 and credit>0.
- SELECT, a client is found:
  - Register its address and one-hot, set grant_valid=1.
  - Decrement its credit and go to WAIT_ACK.
- SELECT, requests pending but none with credit (replenish cycle):
  - Load every credit with its weight; a weight of 0 loads as 1.
  - Stay in SELECT; no grant this cycle.
- SELECT, client_rq==0: go to IDLE.
- WAIT_ACK: grant is held and never revoked, even if the client drops rq. On server_ack=1:
  - grant_valid=0 and grant_onehot=0; address_to_be_served holds its last value.
  - If the granted client's credit is now 0, rr_ptr = granted+1 mod 4. Otherwise rr_ptr = granted, so the burst continues.
  - Go to SELECT.
- Credits and weights:
  - Weights are sampled only on replenish cycles. Changing them mid-round affects the next round only.
  - Credits are unsigned WEIGHT_W bits and never underflow, since a grant requires credit>0.
- Latency:
  - rq rises in IDLE and is sampled at edge k; grant_valid=1 after edge k+1, or k+2 if a replenish is needed.
  - ack sampled at edge m means the next grant appears after edge m+1, so there is at least one cycle with grant_valid=0 between grants.
- Simultaneous events: server_ack together with enable=0 is ignored. The server holds ack until grant_valid falls.
- Reset mid-transfer: grant drops immediately and asynchronously. The first round after reset always starts with a replenish cycle.
- Unused state encoding: go to IDLE with outputs cleared.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- With the macro: an 8-bit wait counter clears on entry to WAIT_ACK and increments each enabled cycle there.
- If the count reaches TIMEOUT_CYCLES-1 without ack, the arbiter:
  - drops the grant and pulses timeout_pulse for one cycle;
  - zeroes the offender's credit;
  - sets rr_ptr = offender+1 and goes to SELECT.
- If ack and timeout land in the same cycle, ack wins and there is no pulse.
- Without the macro: no counter, WAIT_ACK waits indefinitely, and timeout_pulse is constant 0.

Decomposition:
- Shared package arb_pkg:
  - NUM_CLIENTS=4, ADDR_W=2;
  - FSM encodings IDLE=2'b00, SELECT=2'b01, WAIT_ACK=2'b10;
  - client address constants 2'b00..2'b11.
- One combinational sub-module, rr_credit_picker. It takes rq[3:0], a credit-nonzero vector and rr_ptr. It returns found plus a 2-bit index, using rotate, priority-encode and un-rotate.

Test Plan:
- Fairness with weights 1,2,1,3, all rq=1 continuously, ack 1 cycle after each grant. Required grant sequence: 0,1,1,2,3,3,3,0,1,1,… with exactly one replenish cycle (no grant) before each round.
- Single requester, rq=4'b0100, weight 0. Required: a grant to address 2 on every round, with a replenish cycle between consecutive grants.
- Request dropped during a grant to client 1 (rq 1→0 before ack). Required: grant_valid stays 1 until ack, then the arbiter moves to the next requester.
- Freeze: enable=0 for 5 cycles while in WAIT_ACK with ack pulses. Required: outputs and credits unchanged; after re-enable the next ack behaves normally.
- Reset asserted mid-WAIT_ACK. Required: grant_valid=0 and grant_onehot=0 immediately; address=0; after release the first grant follows a replenish cycle and goes to the lowest requesting index ≥0.
- With ARB_TIMEOUT_EN and TIMEOUT_CYCLES=8, client 0 never acked:
  - Required: timeout_pulse after 8 WAIT_ACK cycles, then a grant to the next requester.
  - Ack in the 8th cycle instead gives no pulse.
